cbus_arbiter: RTL and testbench
===============================

Name: cbus_arbiter

Overview:
- Shares the single cache bus between `NUM_REQ` cache-side masters, e.g. ICache as port 0 and DCache as port 1.
- Sits between the caches and the memory-side cbus at the top level.
- Grants one requester at a time, holds the grant for a whole burst, and routes the response only to the owner.
- Default arbitration is round-robin; an optional fixed-priority mode exists.

Parameters:
- NUM_REQ, 2, number of requesting cbus masters (2..8).
- IDX_W, $clog2(NUM_REQ) (minimum 1), width of the grant index. Derived; do not override.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active high
- ireqs  input  NUM_REQ x cbus_req_t  per-requester cbus requests (valid, is_write, size, addr, strobe, data, len, burst)
- iresps  output  NUM_REQ x cbus_resp_t  per-requester responses (ready, last, data)
- oreq  output  cbus_req_t  request to memory side
- oresp  input  cbus_resp_t  response from memory side
- busy  output  1  high while a transaction is granted
- owner  output  IDX_W  index of the current grant holder; 0 when idle

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, oreq = '0, every iresps = '0, busy = 0, owner = 0, rr_ptr = 0.
  - Reset asserted mid-burst aborts the transaction; oreq.valid drops in the same cycle.
- States:
  - IDLE -> GRANT when any ireqs[i].valid is high.
  - GRANT -> IDLE on a cycle with oresp.ready && oresp.last.
  - No other transitions.
- Arbitration (IDLE only):
  - Winner = first valid index searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ..., rr_ptr-1).
  - On the next edge, sel <= winner, owner <= winner, busy <= 1.
  - Grant is registered, so a request reaches oreq one cycle after it is first seen valid in IDLE.
- GRANT routing:
  - oreq = ireqs[sel] (combinational pass-through).
  - iresps[sel] = oresp.
  - All other iresps = '0 (ready = 0); non-owners stall.
- Completion:
  - On oresp.ready && oresp.last: state <= IDLE, busy <= 0, owner <= 0.
  - rr_ptr <= (sel == NUM_REQ-1) ? 0 : sel+1.
  - The following cycle is IDLE with oreq = '0.
  - Minimum turnaround is one idle cycle between bursts (back-to-back bursts from different masters are 1 cycle apart).
- Grant hold:
  - Grant persists until last even if ireqs[sel].valid drops (protocol violation by the requester).
  - In that case oreq.valid follows the requester (goes 0) and the arbiter keeps waiting for last.
- IDLE outputs: oreq = '0 and every iresps = '0, including when requests are pending.
- Simultaneous events:
  - Request arrival on the same cycle as a completing last is not considered until the IDLE cycle.
  - Multiple valids in IDLE are resolved by the rr_ptr order above.
- Single-beat transactions (len = 0) complete on the first ready && last; the memory side asserts last with ready.
- No combinational path from oresp to oreq.

Optional Feature:
- Macro: CBUS_ARB_FIXED_PRIO_EN.
- Defined:
  - Arbitration in IDLE is fixed priority; the lowest valid index wins.
  - rr_ptr is not implemented and is held at 0.
  - Everything else is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Single requester: ireqs[1] read, addr 0x8000_0040, len = 3 (4 beats); oresp.ready for 4 cycles with last on beat 4.
  - oreq.valid rises 1 cycle after ireqs[1].valid; iresps[1] gets 4 ready beats with last on the 4th; iresps[0].ready = 0 throughout.
  - busy deasserts and owner returns to 0 the cycle after the last beat.
- Contention round-robin: ireqs[0] and ireqs[1] both valid from reset release, each doing 2-beat bursts repeatedly.
  - Grant order 0, 1, 0, 1; each owner completes its full burst before the switch.
- Fixed priority (CBUS_ARB_FIXED_PRIO_EN defined): same stimulus as the round-robin test.
  - Port 0 wins every arbitration; port 1 is granted only in an IDLE cycle where ireqs[0].valid = 0.
- Mid-burst reset: reset asserted on beat 2 of a 4-beat write by port 1.
  - oreq.valid = 0 and iresps all zero in the same cycle; busy = 0; after release, a port 0 request is granted first (rr_ptr = 0).
- Write pass-through: port 0 write, strobe 4'b0011, data 0xDEAD_BEEF, len = 0.
  - oreq carries identical fields; completion on a single ready && last; rr_ptr becomes 1.
- Wrap-around with NUM_REQ = 3: ports 0 and 2 valid, rr_ptr = 2 after a port 1 burst.
  - Port 2 is granted, then port 0.

Source files
------------

// File: rtl/cbus_pkg.sv
// cbus_pkg: shared request/response types of the cache bus (cbus).
//   cbus_req_t  : valid, is_write, size, addr, strobe, data, len (beats-1), burst
//   cbus_resp_t : ready, last, data
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_if.sv
// cbus_arbiter_if: bundle of the arbiter's bus-side signals.
//   ireqs  : NUM_REQ cache-side requests   (into the arbiter)
//   iresps : NUM_REQ cache-side responses  (out of the arbiter)
//   oreq   : request to the memory-side cbus (out of the arbiter)
//   oresp  : response from the memory side   (into the arbiter)
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding environment (caches + memory side)
interface cbus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import cbus_pkg::*;

  cbus_req_t  [NUM_REQ-1:0] ireqs;
  cbus_resp_t [NUM_REQ-1:0] iresps;
  cbus_req_t                oreq;
  cbus_resp_t               oresp;

  modport slave  (input ireqs, input oresp, output iresps, output oreq);
  modport master (output ireqs, output oresp, input iresps, input oreq);

endinterface

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares one memory-side cbus between NUM_REQ cache masters.
// One requester is granted at a time; the grant is held for the whole burst
// (until oresp.ready && oresp.last) and the response is routed only to the
// owner. Default arbitration is round-robin starting at rr_ptr.
//
// Optional build macro: CBUS_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest valid index wins, no rr_ptr
//   undefined -> round-robin
//
// Ports:
//   clk    : system clock
//   reset  : asynchronous reset, active high
//   bus    : cbus_arbiter_if.slave (ireqs, iresps, oreq, oresp)
//   busy   : high while a transaction is granted
//   owner  : index of the current grant holder, 0 when idle
module cbus_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  cbus_arbiter_if.slave      bus,
  output logic               busy,
  output logic [IDX_W-1:0]   owner
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic             found;
  int               idx;

`ifdef CBUS_ARB_FIXED_PRIO_EN
  // Searching from index 0 every time gives lowest-index priority.
  assign rr_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  assign rr_ptr = rr_ptr_q;
`endif

  // First valid requester scanning upward from rr_ptr with wrap-around.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.ireqs[idx].valid) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    owner_d = owner_q;
`ifndef CBUS_ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_GRANT;
          sel_d   = winner;
          owner_d = winner;
        end
      end
      ST_GRANT: begin
        // Grant is held until last, even if the owner drops valid early.
        if (bus.oresp.ready && bus.oresp.last) begin
          state_d = ST_IDLE;
          owner_d = '0;
`ifndef CBUS_ARB_FIXED_PRIO_EN
          rr_ptr_d = (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + IDX_W'(1);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      owner_q  <= '0;
`ifndef CBUS_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      owner_q  <= owner_d;
`ifndef CBUS_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Routing depends only on registered state, so there is no oresp->oreq
  // path, and an asynchronous reset drops oreq.valid immediately.
  always_comb begin
    bus.oreq = '0;
    for (int i = 0; i < NUM_REQ; i++) bus.iresps[i] = '0;
    if (state_q == ST_GRANT) begin
      bus.oreq          = bus.ireqs[sel_q];
      bus.iresps[sel_q] = bus.oresp;
    end
  end

  assign busy  = (state_q == ST_GRANT);
  assign owner = owner_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed + randomized bench for cbus_arbiter (NUM_REQ = 3).
// A behavioural model (granted flag, owner, pointer) predicts busy, owner,
// oreq and every iresps; a negedge process compares them every cycle.
// Directed sections pin the model with hand-computed literal expectations.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N  = 3;
  localparam int IW = $clog2(N);
`ifdef CBUS_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          busy;
  logic [IW-1:0] owner;

  cbus_arbiter_if #(.NUM_REQ(N)) bus ();

  cbus_arbiter #(.NUM_REQ(N)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  bit m_busy;
  int m_own;
  int m_ptr;
  bit chk_en = 1'b0;

  cbus_req_t  e_req;
  cbus_resp_t e_rsp;
  cbus_req_t  r0, r1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // First valid index from m_ptr upward with wrap; -1 when none.
  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (bus.ireqs[(m_ptr + k) % N].valid) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_own  = 0;
    m_ptr  = 0;
  endtask

  task automatic model_edge();
    int w;
    if (rst) model_reset();
    else if (!m_busy) begin
      w = pick();
      if (w >= 0) begin
        m_busy = 1'b1;
        m_own  = w;
      end
    end else if (bus.oresp.ready && bus.oresp.last) begin
      m_busy = 1'b0;
      m_ptr  = FIXED ? 0 : (m_own + 1) % N;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_all();
    bus.ireqs = '0;
    bus.oresp = '0;
  endtask

  task automatic finish_beat();
    bus.oresp.ready = 1'b1;
    bus.oresp.last  = 1'b1;
    bus.oresp.data  = $urandom;
    step();
    bus.oresp = '0;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      e_req = m_busy ? bus.ireqs[m_own] : '0;
      chk("busy", 128'(busy), 128'(m_busy));
      chk("owner", 128'(owner), 128'(m_busy ? m_own : 0));
      chk("oreq", 128'(bus.oreq), 128'(e_req));
      for (int i = 0; i < N; i++) begin
        e_rsp = (m_busy && m_own == i) ? bus.oresp : '0;
        chk($sformatf("iresps[%0d]", i), 128'(bus.iresps[i]), 128'(e_rsp));
      end
    end
  end

  initial begin
    int got[$];
    int beat;
    bit prev;

    rst = 1'b1;
    clear_all();
    model_reset();
    step();
    step();
    // Reset state
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_owner", 128'(owner), 128'(0));
    chk("rst_oreq", 128'(bus.oreq), 128'(0));
    chk("rst_iresps", 128'(bus.iresps), 128'(0));
    chk_en = 1'b1;
    rst = 1'b0;
    step();

    // Single requester: port 1 read, 4 beats
    r1 = '0;
    r1.valid = 1'b1; r1.size = 3'd2; r1.addr = 32'h8000_0040; r1.len = 8'd3; r1.burst = 2'd1;
    bus.ireqs[1] = r1;
    #1;
    chk("idle_oreq_pending", 128'(bus.oreq), 128'(0));
    chk("idle_iresp1_pending", 128'(bus.iresps[1]), 128'(0));
    step();
    chk("t1_busy", 128'(busy), 128'(1));
    chk("t1_owner", 128'(owner), 128'(1));
    chk("t1_oreq_addr", 128'(bus.oreq.addr), 128'(32'h8000_0040));
    chk("t1_oreq_valid", 128'(bus.oreq.valid), 128'(1));
    for (int b = 0; b < 4; b++) begin
      bus.oresp.ready = 1'b1;
      bus.oresp.last  = (b == 3);
      bus.oresp.data  = 32'h100 + b;
      #1;
      chk("t1_ready1", 128'(bus.iresps[1].ready), 128'(1));
      chk("t1_last1", 128'(bus.iresps[1].last), 128'(b == 3));
      chk("t1_data1", 128'(bus.iresps[1].data), 128'(32'h100 + b));
      chk("t1_ready0", 128'(bus.iresps[0].ready), 128'(0));
      step();
    end
    clear_all();
    #1;
    chk("t1_done_busy", 128'(busy), 128'(0));
    chk("t1_done_owner", 128'(owner), 128'(0));
    chk("t1_done_valid", 128'(bus.oreq.valid), 128'(0));

    // Write pass-through: port 0, single beat
    r0 = '0;
    r0.valid = 1'b1; r0.is_write = 1'b1; r0.size = 3'd2; r0.addr = 32'h0000_1000;
    r0.strobe = 4'b0011; r0.data = 32'hDEAD_BEEF; r0.len = 8'd0;
    bus.ireqs[0] = r0;
    step();
    chk("wr_oreq", 128'(bus.oreq), 128'(r0));
    chk("wr_owner", 128'(owner), 128'(0));
    finish_beat();
    bus.ireqs = '0;
    #1;
    chk("wr_done_busy", 128'(busy), 128'(0));
    // Pointer now 1 in round-robin: port 1 beats port 0
    bus.ireqs[0] = r0;
    bus.ireqs[1] = r1;
    step();
    chk("wr_next_owner", 128'(owner), 128'(FIXED ? 0 : 1));
    finish_beat();
    clear_all();
    step();

    // Contention from reset release, 2-beat bursts
    rst = 1'b1;
    model_reset();
    step();
    r0.len = 8'd1;
    r1.len = 8'd1;
    bus.ireqs[0] = r0;
    bus.ireqs[1] = r1;
    rst = 1'b0;
    beat = 0;
    prev = 1'b0;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      if (busy && !prev) got.push_back(int'(owner));
      prev = busy;
      if (m_busy) begin
        bus.oresp.ready = 1'b1;
        bus.oresp.last  = (beat == 1);
        bus.oresp.data  = $urandom;
        beat = (beat == 1) ? 0 : 1;
      end else bus.oresp = '0;
      step();
    end
    chk("cont_ngrants", 128'(got.size()), 128'(4));
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("cont_grant%0d", i), 128'(got[i]), 128'(FIXED ? 0 : (i % 2)));

    // Owner drops valid mid-burst: grant held, oreq.valid follows requester
    clear_all();
    step();
    chk("hold_busy", 128'(busy), 128'(1));
    chk("hold_valid", 128'(bus.oreq.valid), 128'(0));
    finish_beat();
    step();

    // Mid-burst reset on beat 2 of a port 1 write
    r1.is_write = 1'b1; r1.len = 8'd3; r1.data = 32'h1234_5678; r1.strobe = 4'hF;
    bus.ireqs[1] = r1;
    step();
    bus.oresp.ready = 1'b1;
    bus.oresp.last  = 1'b0;
    step();
    rst = 1'b1;
    model_reset();
    #1;
    chk("mrst_valid", 128'(bus.oreq.valid), 128'(0));
    chk("mrst_iresps", 128'(bus.iresps), 128'(0));
    chk("mrst_busy", 128'(busy), 128'(0));
    step();
    rst = 1'b0;
    bus.oresp = '0;
    bus.ireqs[0] = r0;
    step();
    chk("mrst_owner", 128'(owner), 128'(0));
    chk("mrst_busy2", 128'(busy), 128'(1));
    finish_beat();
    clear_all();
    step();

    // Wrap-around: port 1 burst, then ports 0 and 2 contend
    bus.ireqs[1] = r1;
    step();
    finish_beat();
    bus.ireqs = '0;
    bus.ireqs[0] = r0;
    bus.ireqs[2] = r1;
    step();
    chk("wrap_first", 128'(owner), 128'(FIXED ? 0 : 2));
    finish_beat();
    step();
    chk("wrap_second", 128'(owner), 128'(0));
    finish_beat();
    clear_all();
    step();

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) bus.ireqs[i].valid = ~bus.ireqs[i].valid;
        bus.ireqs[i].is_write = 1'($urandom);
        bus.ireqs[i].size     = 3'($urandom);
        bus.ireqs[i].addr     = $urandom;
        bus.ireqs[i].strobe   = 4'($urandom);
        bus.ireqs[i].data     = $urandom;
        bus.ireqs[i].len      = 8'($urandom);
        bus.ireqs[i].burst    = 2'($urandom);
      end
      bus.oresp.ready = ($urandom_range(0, 1) == 1);
      bus.oresp.last  = bus.oresp.ready && ($urandom_range(0, 2) == 0);
      bus.oresp.data  = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    clear_all();
    step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
